// File: rtl/tb_uart_rx_monitor.sv
// UART receive monitor for the simulation fixture: turns the SoC uart_tx
// stream into bytes and hands them to the console/checker through a small
// first-word-fall-through FIFO.
//
//   state | meaning
//   IDLE  | line idle, watching for a falling edge on the synchronised line
//   START | counting to the middle of the start bit to reject glitches
//   DATA  | sampling 8 data bits LSB first, one per bit period
//   STOP  | counting to the middle of the stop bit
//   BREAK | stop bit was low; wait for the line to return high
module tb_uart_rx_monitor #(
  parameter int CyclesPerBit = 434,
  parameter int FifoDepth    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         uart_rx_i,
  input  logic                         clear_i,
  output logic [7:0]                   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         frame_err_o,
  output logic                         overflow_o,
  output logic                         busy_o,
  output logic [$clog2(FifoDepth):0]   level_o
);

  localparam int CntW = $clog2(CyclesPerBit);
  localparam int PtrW = $clog2(FifoDepth);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CyclesPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(CyclesPerBit - 1);
  localparam logic [PtrW:0]   DepthVal = (PtrW + 1)'(FifoDepth);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t            state, state_nxt;
  logic              rx_meta, rx_s, rx_q;
  logic [CntW-1:0]   cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              cnt_zero, fall, push;

  logic [7:0]        mem [FifoDepth];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [PtrW:0]     count;
  logic [7:0]        last_q;
  logic              full, pop, wr_en;

  assign cnt_zero = (cnt == '0);
  assign fall     = rx_q & ~rx_s;

  // Two-stage synchroniser plus one delay stage for edge detection; idles high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (cnt_zero) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (cnt_zero && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (cnt_zero) state_nxt = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: activity flag, byte push and framing-error pulse at the stop sample.
  always_comb begin
    busy_o      = (state != IDLE);
    push        = (state == STOP) && cnt_zero && rx_s;
    frame_err_o = (state == STOP) && cnt_zero && !rx_s;
  end

  // Bit timer (down-counter to zero), bit index and LSB-first shift register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: if (fall) cnt <= HalfLoad;
        START: begin
          if (cnt_zero) begin
            cnt     <= FullLoad;
            bit_idx <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt_zero) begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= FullLoad;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: if (!cnt_zero) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign full    = (count == DepthVal);
  assign valid_o = (count != '0);
  assign pop     = valid_o & ready_i;
  // A push into a full FIFO only succeeds when the head leaves in the same cycle.
  assign wr_en   = push & (~full | pop);
  assign level_o = count;
  assign data_o  = valid_o ? mem[rd_ptr] : last_q;

  // FIFO storage; contents need no reset since valid_o gates the head.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy, held head value and sticky overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_q     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (valid_o) last_q <= mem[rd_ptr];
      if (push && full && !pop) overflow_o <= 1'b1;
      else if (clear_i)         overflow_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tb_uart_rx_monitor.sv
// Bench for the UART receive monitor: directed frames with a cycle-level
// reference model compared on every falling clock edge, plus literal checks.
module tb_tb_uart_rx_monitor;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, uart_rx, clear, ready;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, overflow_o, busy_o;
  logic [2:0] level_o;

  int checks = 0;
  int errors = 0;

  tb_uart_rx_monitor #(.CyclesPerBit(CPB), .FifoDepth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .uart_rx_i(uart_rx), .clear_i(clear),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready),
    .frame_err_o(frame_err_o), .overflow_o(overflow_o),
    .busy_o(busy_o), .level_o(level_o)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: line as seen after two register stages, bit sampling at
  // CPB/2 + k*CPB cycles after the detected falling edge, FIFO as a queue.
  bit         m_meta, m_s, m_q;
  bit         m_active, m_break;
  int         m_t;
  logic [7:0] m_bits;
  logic [7:0] q[$];
  logic [7:0] m_last;
  bit         m_ov;
  logic [7:0] got[$];
  int         fe_count = 0;

  task automatic model_reset();
    m_meta = 1; m_s = 1; m_q = 1;
    m_active = 0; m_break = 0; m_t = 0; m_bits = '0;
    q.delete(); m_last = '0; m_ov = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    bit e_busy, e_fe, e_push, e_valid, pop_now, ovf_now;
    logic [7:0] e_data;
    int off, k;
    if (rst) model_reset();
    e_busy = m_active || m_break;
    e_fe = 0;
    e_push = 0;
    if (!rst) begin
      if (m_break) begin
        if (m_s) m_break = 0;
      end else if (!m_active) begin
        if (m_q && !m_s) begin m_active = 1; m_t = 1; end
      end else begin
        off = m_t - CPB / 2;
        if (off >= 0 && off % CPB == 0) begin
          k = off / CPB;
          if (k == 0) begin
            if (m_s) m_active = 0;
          end else if (k <= 8) begin
            m_bits[k-1] = m_s;
          end else begin
            m_active = 0;
            if (m_s) e_push = 1;
            else begin e_fe = 1; m_break = 1; end
          end
        end
        m_t++;
      end
    end
    e_valid = (q.size() != 0);
    e_data  = e_valid ? q[0] : m_last;
    check("busy", busy_o, e_busy);
    check("frame_err", frame_err_o, e_fe);
    check("valid", valid_o, e_valid);
    check("data", data_o, e_data);
    check("level", level_o, q.size());
    check("overflow", overflow_o, m_ov);
    if (valid_o && ready) got.push_back(data_o);
    if (frame_err_o) fe_count++;
    if (!rst) begin
      pop_now = e_valid && ready;
      if (pop_now) m_last = q.pop_front();
      ovf_now = 0;
      if (e_push) begin
        if (q.size() == DEPTH) begin ovf_now = 1; m_ov = 1; end
        else q.push_back(m_bits);
      end
      if (clear && !ovf_now) m_ov = 0;
      m_q = m_s;
      m_s = m_meta;
      m_meta = uart_rx;
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_line(bit v, int n);
    uart_rx = v;
    tick(n);
  endtask

  // Full frame; optionally raise ready for exactly the stop-sample cycle.
  task automatic send_byte(logic [7:0] b, bit stop_v = 1, int stop_n = CPB, bit pulse_ready = 0);
    drive_line(0, CPB);
    for (int i = 0; i < 8; i++) drive_line(b[i], CPB);
    uart_rx = stop_v;
    for (int i = 0; i < stop_n; i++) begin
      if (pulse_ready) ready = (i == 2 + CPB / 2);
      tick(1);
    end
    if (pulse_ready) ready = 0;
    uart_rx = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, f;
    rst = 1; uart_rx = 1; clear = 0; ready = 1;
    tick(3);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_level", level_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    rst = 0;
    tick(4);

    // Single frame 0x41
    n = got.size();
    send_byte(8'h41);
    tick(CPB);
    check("t1_count", got.size(), n + 1);
    check("t1_byte", got[n], 8'h41);
    check("t1_fe", fe_count, 0);
    check("t1_busy", busy_o, 0);

    // Short low glitch
    n = got.size(); f = fe_count;
    drive_line(0, 3);
    drive_line(1, 3 * CPB);
    check("t2_count", got.size(), n);
    check("t2_fe", fe_count, f);
    check("t2_busy", busy_o, 0);

    // Framing error then recovery
    send_byte(8'h55, 0, 20);
    drive_line(1, 2 * CPB);
    check("t3_fe", fe_count, f + 1);
    check("t3_nobyte", got.size(), n);
    send_byte(8'h0A);
    tick(CPB);
    check("t3_count", got.size(), n + 1);
    check("t3_byte", got[n], 8'h0A);

    // Fill with consumer stalled, overflow, drain, clear
    ready = 0;
    for (int b = 1; b <= 5; b++) send_byte(8'(b));
    tick(CPB);
    check("t4_level", level_o, 4);
    check("t4_overflow", overflow_o, 1);
    check("t4_head", data_o, 8'h01);
    n = got.size();
    ready = 1;
    tick(6);
    ready = 0;
    check("t4_count", got.size(), n + 4);
    for (int i = 0; i < 4; i++) check("t4_drain", got[n+i], 32'(i + 1));
    check("t4_empty", level_o, 0);
    check("t4_hold", data_o, 8'h04);
    clear = 1;
    tick(1);
    clear = 0;
    check("t4_clear", overflow_o, 0);

    // Push and pop together while full
    for (int b = 0; b < 4; b++) send_byte(8'(8'h11 + b));
    n = got.size();
    send_byte(8'h15, 1, CPB, 1);
    tick(CPB);
    check("t5_level", level_o, 4);
    check("t5_overflow", overflow_o, 0);
    check("t5_popped", got[n], 8'h11);
    check("t5_head", data_o, 8'h12);
    ready = 1;
    tick(6);
    ready = 0;
    check("t5_count", got.size(), n + 5);
    check("t5_tail", got[n+4], 8'h15);

    // Reset mid-frame
    send_byte(8'h77);
    tick(CPB);
    check("t6_level_pre", level_o, 1);
    drive_line(0, CPB);
    drive_line(1, CPB);
    drive_line(0, CPB / 2);
    rst = 1;
    uart_rx = 1;
    tick(1);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_valid", valid_o, 0);
    check("t6_rst_level", level_o, 0);
    check("t6_rst_data", data_o, 0);
    check("t6_rst_overflow", overflow_o, 0);
    check("t6_rst_fe", frame_err_o, 0);
    tick(CPB);
    rst = 0;
    tick(2 * CPB);
    n = got.size();
    ready = 1;
    send_byte(8'h3C);
    tick(CPB);
    check("t6_count", got.size(), n + 1);
    check("t6_byte", got[n], 8'h3C);
    check("t6_level", level_o, 0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
